// File: rtl/ps2_keyboard_rx_if.sv
// Bundle of the PS/2 pins and the decoded key outputs.
// The receiver takes the master side. A consumer or stimulus source takes the slave side.
interface ps2_keyboard_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       keypress;
  logic       extended;
  logic       code_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output keycode,
    output keypress,
    output extended,
    output code_valid,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  keycode,
    input  keypress,
    input  extended,
    input  code_valid,
    input  frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver. It synchronises and glitch-filters the PS/2 pins, assembles 11-bit frames,
// and decodes F0/E0-prefixed scan codes into keycode/keypress/extended.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  ps2_keyboard_rx_if.master bus
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      FILT_MAX = 8'(FILTER_LEN - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic            clk_meta, clk_sync, dat_meta, dat_sync;
  logic            filt_clk;
  logic [7:0]      filt_cnt;
  logic            filt_hit, fall;
  state_t          state, state_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic            par_err, par_err_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            emit_nxt, err_nxt;
  logic [7:0]      shift;
  logic            vld_p1, err_p1;
  logic [7:0]      byte_p1;
  logic [7:0]      keycode_p2;
  logic            keypress_p2, extended_p2, vld_p2;
  logic            brk_pend, ext_pend;

  // Stage: two-flop synchronisers. They idle high, which matches the bus idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= bus.ps2_clk;
      clk_sync <= clk_meta;
      dat_meta <= bus.ps2_data;
      dat_sync <= dat_meta;
    end
  end

  // Stage: glitch filter. fall is high in the cycle where the filtered clock commits to 0.
  assign filt_hit = (clk_sync != filt_clk) && (filt_cnt == FILT_MAX);
  assign fall     = filt_hit && filt_clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_hit) begin
      filt_clk <= clk_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // Stage: frame FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      par_err <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_err <= par_err_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (fall && state == DATA) shift <= {dat_sync, shift[7:1]};
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    par_err_nxt = par_err;
    emit_nxt    = 1'b0;
    err_nxt     = 1'b0;
    to_cnt_nxt  = (state == IDLE || fall) ? '0 : to_cnt + 1'b1;
    if (state != IDLE && !fall && to_cnt == TO_MAX) begin
      state_nxt  = IDLE;
      err_nxt    = 1'b1;
      to_cnt_nxt = '0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_sync) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        DATA: begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          // Odd parity: the XOR over the data bits and the parity bit must be 1.
          par_err_nxt = ~(^shift ^ dat_sync);
          state_nxt   = STOP;
        end
        STOP: begin
          if (dat_sync && !par_err) emit_nxt = 1'b1;
          else                      err_nxt  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage: emitted byte / error strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= emit_nxt;
      err_p1 <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (emit_nxt) byte_p1 <= shift;
  end

  // Stage: prefix decoder and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keycode_p2  <= 8'h00;
      keypress_p2 <= 1'b0;
      extended_p2 <= 1'b0;
      vld_p2      <= 1'b0;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (vld_p1) begin
        case (byte_p1)
          8'hF0: brk_pend <= 1'b1;
          8'hE0: ext_pend <= 1'b1;
          default: begin
            keycode_p2  <= byte_p1;
            keypress_p2 <= ~brk_pend;
            extended_p2 <= ext_pend;
            vld_p2      <= 1'b1;
            brk_pend    <= 1'b0;
            ext_pend    <= 1'b0;
          end
        endcase
      end else if (err_p1) begin
        // Drop partial prefixes so a truncated break never turns a later make into a break.
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end
    end
  end

  assign bus.keycode    = keycode_p2;
  assign bus.keypress   = keypress_p2;
  assign bus.extended   = extended_p2;
  assign bus.code_valid = vld_p2;
  assign bus.frame_err  = err_p1;

endmodule
